// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline control blocks.
// Forwarding-select encodings, stage metadata and the hazard match helper.
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } stage_t;

  // Register 0 is hard-wired, so a write to it is never a real producer.
  function automatic logic src_match(input logic [REG_W-1:0] src, input stage_t s);
    return s.reg_write && (s.dest != '0) && (s.dest == src);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage holding destination metadata.
// Clear inserts a bubble and takes priority over load; otherwise the stage holds.
module hazard_stage_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and EX-stage forwarding control for the 5-stage pipeline.
// Shadows the ID/EX, EX/MEM and MEM/WB destination metadata internally.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int FWD_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             freeze,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             stall,
  output logic             bubble
);

  mips_pkg::stage_t id_meta;
  mips_pkg::stage_t idex;
  mips_pkg::stage_t exmem;
  mips_pkg::stage_t memwb;

  logic             advance;
  logic             load_use;
  logic             a_hit_ex;
  logic             a_hit_mem;
  logic             b_hit_ex;
  logic             b_hit_mem;
  logic [FWD_W-1:0] next_a;
  logic [FWD_W-1:0] next_b;
  logic             unused_memwb;

  assign id_meta.dest      = id_dest;
  assign id_meta.reg_write = id_reg_write;
  assign id_meta.mem_read  = id_mem_read;

  assign advance = ~freeze;

  hazard_stage_reg u_idex (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (bubble),
    .d     (id_meta),
    .q     (idex)
  );

  hazard_stage_reg u_exmem (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (1'b0),
    .d     (idex),
    .q     (exmem)
  );

  // MEM/WB is tracked for completeness; the write-before-read regfile covers it.
  hazard_stage_reg u_memwb (
    .clk   (clk),
    .rst   (rst),
    .load  (advance),
    .clear (1'b0),
    .d     (exmem),
    .q     (memwb)
  );

  assign unused_memwb = ^memwb;

  assign a_hit_ex  = mips_pkg::src_match(id_rs, idex);
  assign a_hit_mem = mips_pkg::src_match(id_rs, exmem);
  assign b_hit_ex  = mips_pkg::src_match(id_rt, idex);
  assign b_hit_mem = mips_pkg::src_match(id_rt, exmem);

  assign load_use = idex.mem_read & (a_hit_ex | (id_uses_rt & b_hit_ex));
  assign stall    = load_use | freeze;
  assign bubble   = load_use & ~freeze;

  // The instruction now in EX is the nearer producer and wins over EX/MEM.
  always_comb begin
    next_a = mips_pkg::FWD_REG;
    next_b = mips_pkg::FWD_REG;
    if (a_hit_ex && !idex.mem_read) begin
      next_a = mips_pkg::FWD_MEM;
    end else if (a_hit_mem) begin
      next_a = mips_pkg::FWD_WB;
    end
    if (id_uses_rt) begin
      if (b_hit_ex && !idex.mem_read) begin
        next_b = mips_pkg::FWD_MEM;
      end else if (b_hit_mem) begin
        next_b = mips_pkg::FWD_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= mips_pkg::FWD_REG;
      fwd_b <= mips_pkg::FWD_REG;
    end else if (advance) begin
      if (load_use) begin
        fwd_a <= mips_pkg::FWD_REG;
        fwd_b <= mips_pkg::FWD_REG;
      end else begin
        fwd_a <= next_a;
        fwd_b <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand sequences,
// and randomized traffic compared against a distance-based pipeline model.
module tb_hazard_unit;

  typedef struct {
    bit         rst;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         uses_rt;
    logic [4:0] dest;
    bit         rw;
    bit         mr;
    bit         frz;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    bit         exp_stall;
    bit         exp_bubble;
  } vec_t;

  typedef struct {
    logic [4:0] dest;
    bit         rw;
    bit         mr;
  } meta_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_dest;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       freeze;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic       bubble;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: slot 0 is the instruction in EX, slot 1 in MEM, slot 2 in WB.
  meta_t      pipe[3];
  logic [1:0] m_fwd_a;
  logic [1:0] m_fwd_b;

  vec_t table_v[$];

  hazard_unit #(.REG_W(5), .FWD_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .freeze       (freeze),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall),
    .bubble       (bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, int rs_i, int rt_i, bit u, int d, bit w, bit m, bit f,
                              int ea, int eb, bit es, bit ebb);
    vec_t v;
    v.rst = r; v.rs = 5'(rs_i); v.rt = 5'(rt_i); v.uses_rt = u;
    v.dest = 5'(d); v.rw = w; v.mr = m; v.frz = f;
    v.exp_a = 2'(ea); v.exp_b = 2'(eb); v.exp_stall = es; v.exp_bubble = ebb;
    return v;
  endfunction

  // Distance (0 = EX, 1 = MEM) of the nearest in-flight writer of src, or -1.
  function automatic int nearest(logic [4:0] src);
    for (int d = 0; d < 2; d++) begin
      if (pipe[d].rw && pipe[d].dest != 0 && pipe[d].dest == src) return d;
    end
    return -1;
  endfunction

  function automatic logic [1:0] model_sel(logic [4:0] src, bit used);
    int d;
    if (!used) return 2'b00;
    d = nearest(src);
    if (d == 0) return pipe[0].mr ? 2'b00 : 2'b01;
    if (d == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit model_load_use(vec_t v);
    return (nearest(v.rs) == 0 && pipe[0].mr) ||
           (v.uses_rt && nearest(v.rt) == 0 && pipe[0].mr);
  endfunction

  task automatic modelStep(input vec_t v);
    bit lu;
    meta_t nop;
    meta_t cur;
    nop.dest = 0; nop.rw = 0; nop.mr = 0;
    cur.dest = v.dest; cur.rw = v.rw; cur.mr = v.mr;
    if (v.rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = nop;
      m_fwd_a = 2'b00;
      m_fwd_b = 2'b00;
    end else if (!v.frz) begin
      lu = model_load_use(v);
      m_fwd_a = lu ? 2'b00 : model_sel(v.rs, 1'b1);
      m_fwd_b = lu ? 2'b00 : model_sel(v.rt, v.uses_rt);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = lu ? nop : cur;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst          = v.rst;
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rt   = v.uses_rt;
    id_dest      = v.dest;
    id_reg_write = v.rw;
    id_mem_read  = v.mr;
    freeze       = v.frz;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkModel(input int cyc, input vec_t v);
    bit lu;
    lu = model_load_use(v);
    checkOutput($sformatf("rand%0d fwd_a", cyc), fwd_a, m_fwd_a);
    checkOutput($sformatf("rand%0d fwd_b", cyc), fwd_b, m_fwd_b);
    checkOutput($sformatf("rand%0d stall", cyc), {1'b0, stall}, {1'b0, lu | v.frz});
    checkOutput($sformatf("rand%0d bubble", cyc), {1'b0, bubble}, {1'b0, lu & ~v.frz});
  endtask

  initial begin
    vec_t v;
    vec_t rv;

    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_dest = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; freeze = 1'b0;

    // rst rs rt u dest w m f | a b stall bubble
    table_v.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // load-use on rt
    table_v.push_back(mk(0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    table_v.push_back(mk(0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    // register zero
    table_v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // freeze in the middle of an EX/MEM forward
    table_v.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // freeze together with a load-use hazard
    table_v.push_back(mk(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    table_v.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    table_v.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    // reset asserted mid-stall
    table_v.push_back(mk(0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    table_v.push_back(mk(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // back-to-back dependent loads
    table_v.push_back(mk(0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 7, 0, 0, 10, 1, 1, 0, 0, 0, 1, 1));
    table_v.push_back(mk(0, 7, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 10, 1, 0, 0, 0, 0, 2, 0, 1, 1));
    table_v.push_back(mk(0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));

    // Two reset clocks before the table starts.
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(v);
      modelStep(v);
    end

    for (int i = 0; i < table_v.size(); i++) begin
      v = table_v[i];
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("row%0d fwd_a", i), fwd_a, v.exp_a);
      checkOutput($sformatf("row%0d fwd_b", i), fwd_b, v.exp_b);
      checkOutput($sformatf("row%0d stall", i), {1'b0, stall}, {1'b0, v.exp_stall});
      checkOutput($sformatf("row%0d bubble", i), {1'b0, bubble}, {1'b0, v.exp_bubble});
      modelStep(v);
    end

    for (int c = 0; c < 600; c++) begin
      rv.rst     = ($urandom_range(0, 63) == 0);
      rv.rs      = 5'($urandom_range(0, 3));
      rv.rt      = 5'($urandom_range(0, 3));
      rv.uses_rt = 1'($urandom_range(0, 1));
      rv.dest    = 5'($urandom_range(0, 3));
      rv.rw      = ($urandom_range(0, 3) != 0);
      rv.mr      = ($urandom_range(0, 2) == 0);
      rv.frz     = ($urandom_range(0, 7) == 0);
      rv.exp_a = 2'b00; rv.exp_b = 2'b00; rv.exp_stall = 1'b0; rv.exp_bubble = 1'b0;
      applyStimulus(rv);
      @(negedge clk);
      checkModel(c, rv);
      modelStep(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
